// File: rtl/mic_pkg.sv
// Shared types and defaults for the PDM microphone receiver.
// Holds the FSM state enum, default sizes and the accumulator width helper.
package mic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    RUN
  } state_e;

  localparam int DEF_DECIM = 64;
  localparam int DEF_PCM_W = 16;

  function automatic int acc_w(input int decim);
    return $clog2(decim + 1);
  endfunction

endpackage

// File: rtl/mic_pdm_rx_if.sv
// PCM sample stream with a valid/ready handshake.
// master: drives pcm_data/pcm_valid, samples pcm_ready; slave: the reverse.
interface mic_pdm_rx_if
  import mic_pkg::*;
#(
  parameter int PCM_W = DEF_PCM_W
);

  logic [PCM_W-1:0] pcm_data;
  logic             pcm_valid;
  logic             pcm_ready;

  modport master (
    output pcm_data,
    output pcm_valid,
    input  pcm_ready
  );

  modport slave (
    input  pcm_data,
    input  pcm_valid,
    output pcm_ready
  );

endinterface

// File: rtl/mic_edge_sync.sv
// Two-flop synchroniser and rising-edge detect for mic_clk, with pdm_data
// delayed through identical stages. Ports: s_clk, n_rst, mic_clk, pdm_data in; edge_stb, pdm_bit out.
module mic_edge_sync (
  input  logic s_clk,
  input  logic n_rst,
  input  logic mic_clk,
  input  logic pdm_data,
  output logic edge_stb,
  output logic pdm_bit
);

  logic [1:0] mic_sync_q, mic_sync_d;
  logic [1:0] pdm_sync_q, pdm_sync_d;
  logic       mic_prev_q, mic_prev_d;

  always_comb begin
    mic_sync_d = {mic_sync_q[0], mic_clk};
    pdm_sync_d = {pdm_sync_q[0], pdm_data};
    mic_prev_d = mic_sync_q[1];
  end

  always_ff @(posedge s_clk or negedge n_rst) begin
    if (!n_rst) begin
      mic_sync_q <= '0;
      pdm_sync_q <= '0;
      mic_prev_q <= 1'b0;
    end else begin
      mic_sync_q <= mic_sync_d;
      pdm_sync_q <= pdm_sync_d;
      mic_prev_q <= mic_prev_d;
    end
  end

  assign edge_stb = mic_sync_q[1] & ~mic_prev_q;
  assign pdm_bit  = pdm_sync_q[1];

endmodule

// File: rtl/mic_pdm_rx.sv
// PDM microphone receiver: samples PDM bits on mic_clk rises, ones-counts DECIM
// bits into a signed PCM word. Ports: s_clk, n_rst, en, mic_clk, pdm_data, pcm (master), overrun/clr_ovr, clk_lost.
module mic_pdm_rx
  import mic_pkg::*;
#(
  parameter int DECIM   = DEF_DECIM,
  parameter int PCM_W   = DEF_PCM_W,
  parameter int WARMUP  = 4,
  parameter int TIMEOUT = 256
) (
  input  logic          s_clk,
  input  logic          n_rst,
  input  logic          en,
  input  logic          mic_clk,
  input  logic          pdm_data,
  mic_pdm_rx_if.master  pcm,
  output logic          overrun,
  input  logic          clr_ovr,
  output logic          clk_lost
);

  localparam int ACC_W = acc_w(DECIM);
  localparam int CNT_W = $clog2(DECIM);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int WU_W  = $clog2(WARMUP + 2);

  logic edge_stb;
  logic pdm_bit;

  mic_edge_sync u_sync (
    .s_clk    (s_clk),
    .n_rst    (n_rst),
    .mic_clk  (mic_clk),
    .pdm_data (pdm_data),
    .edge_stb (edge_stb),
    .pdm_bit  (pdm_bit)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [ACC_W-1:0] ones_q, ones_d;
  logic [WU_W-1:0]  warm_q, warm_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [PCM_W-1:0] pcm_data_q, pcm_data_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic             overrun_q, overrun_d;
  logic             clk_lost_q, clk_lost_d;

  logic [ACC_W-1:0] ones_sum;
  logic [PCM_W-1:0] sample;
  logic             frame_done;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    warm_d      = warm_q;
    to_d        = to_q;
    pcm_data_d  = pcm_data_q;
    pcm_valid_d = pcm_valid_q & ~pcm.pcm_ready;
    overrun_d   = overrun_q & ~clr_ovr;
    clk_lost_d  = clk_lost_q;
    ones_sum    = ones_q + ACC_W'(pdm_bit);
    // 2*ones - DECIM maps all-zeros to -DECIM and all-ones to +DECIM
    sample      = (PCM_W'(ones_sum) << 1) - PCM_W'(DECIM);
    frame_done  = edge_stb && (bit_cnt_q == CNT_W'(DECIM - 1));

    if (!en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      ones_d    = '0;
      warm_d    = '0;
      to_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WARM;
        WARM, RUN: begin
          if (edge_stb) begin
            to_d = '0;
            if (frame_done) begin
              bit_cnt_d = '0;
              ones_d    = '0;
              if (state_q == WARM) begin
                warm_d = warm_q + WU_W'(1);
                if (warm_q == WU_W'(WARMUP - 1)) begin
                  state_d    = RUN;
                  warm_d     = '0;
                  clk_lost_d = 1'b0;
                end
              end else if (pcm_valid_q && !pcm.pcm_ready) begin
                overrun_d = 1'b1;
              end else begin
                pcm_data_d  = sample;
                pcm_valid_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
              ones_d    = ones_sum;
            end
          end else if (to_q == TO_W'(TIMEOUT - 1)) begin
            // lost clock: redo the warm-up once edges come back
            clk_lost_d = 1'b1;
            state_d    = WARM;
            bit_cnt_d  = '0;
            ones_d     = '0;
            warm_d     = '0;
            to_d       = '0;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge s_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      warm_q      <= '0;
      to_q        <= '0;
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      clk_lost_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      warm_q      <= warm_d;
      to_q        <= to_d;
      pcm_data_q  <= pcm_data_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
      clk_lost_q  <= clk_lost_d;
    end
  end

  assign pcm.pcm_data  = pcm_data_q;
  assign pcm.pcm_valid = pcm_valid_q;
  assign overrun       = overrun_q;
  assign clk_lost      = clk_lost_q;

endmodule
